fila_ctrl: RTL and testbench

Initiator-side controller for the 8-entry byte queue (`fila`). It turns raw push-buttons and an 8-bit switch bank into well-formed single-cycle `enqueue`/`dequeue` requests. It refuses requests the queue cannot honour (full or empty) and captures each popped byte. It sits between the board I/O and the queue instance, and feeds the display logic with popped data and status.

---
 rtl/fila_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fila_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fila_ctrl.sv
// rtl/fila_ctrl.sv - button-driven enqueue/dequeue request controller for the byte queue
module fila_ctrl #(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int DEPTH           = 8
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       btn_enq,
  input  logic       btn_deq,
  input  logic [7:0] sw_data,
  input  logic [7:0] len_in,
  input  logic [7:0] data_in,
  output logic       enqueue_out,
  output logic       dequeue_out,
  output logic [7:0] data_to_fila,
  output logic [7:0] popped_out,
  output logic       popped_valid,
  output logic       full_out,
  output logic       empty_out,
  output logic       err_out
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    DEPTH_L  = 8'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ENQ, S_DEQ, S_WAIT} state_t;

  // Bit 0 is the enqueue button, bit 1 the dequeue button.
  logic [1:0]    w_btn;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_db;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    w_rise;

  state_t r_state;
  state_t w_state_next;
  logic   r_pend_enq;
  logic   r_pend_deq;
  logic   r_was_deq;
  logic   w_clr_enq;
  logic   w_clr_deq;
  logic   w_take_data;
  logic   w_err;

  assign w_btn     = {btn_deq, btn_enq};
  assign full_out  = (len_in >= DEPTH_L);
  assign empty_out = (len_in == 8'd0);

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level flips after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      r_db     <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i] <= '0;
          r_db[i]  <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced rising edge, asserted in the cycle whose clock edge flips the level to 1.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < 2; i++) begin
      w_rise[i] = r_sync2[i] & ~r_db[i] & (r_cnt[i] == CNT_LAST);
    end
  end

  // Pending request flags; an edge arriving while a flag is already set is absorbed.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      r_pend_enq <= 1'b0;
      r_pend_deq <= 1'b0;
    end else begin
      r_pend_enq <= w_clr_enq ? 1'b0 : (r_pend_enq | w_rise[0]);
      r_pend_deq <= w_clr_deq ? 1'b0 : (r_pend_deq | w_rise[1]);
    end
  end

  // FSM state register; was_deq remembers whether the strobe before WAIT was a dequeue.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_was_deq <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_was_deq <= (r_state == S_DEQ);
    end
  end

  // Next-state decode and strobes; enqueue has priority, full/empty judged only in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_clr_enq    = 1'b0;
    w_clr_deq    = 1'b0;
    w_take_data  = 1'b0;
    w_err        = 1'b0;
    enqueue_out  = 1'b0;
    dequeue_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_enq) begin
          w_clr_enq = 1'b1;
          if (full_out) begin
            w_err = 1'b1;
          end else begin
            w_take_data  = 1'b1;
            w_state_next = S_ENQ;
          end
        end else if (r_pend_deq) begin
          w_clr_deq = 1'b1;
          if (empty_out) begin
            w_err = 1'b1;
          end else begin
            w_state_next = S_DEQ;
          end
        end
      end
      S_ENQ: begin
        enqueue_out  = 1'b1;
        w_state_next = S_WAIT;
      end
      S_DEQ: begin
        dequeue_out  = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output registers: held enqueue byte, captured popped byte, and the one-cycle pulses.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      data_to_fila <= 8'h00;
      popped_out   <= 8'h00;
      popped_valid <= 1'b0;
      err_out      <= 1'b0;
    end else begin
      if (w_take_data) begin
        data_to_fila <= sw_data;
      end
      popped_valid <= 1'b0;
      if ((r_state == S_WAIT) && r_was_deq) begin
        popped_out   <= data_in;
        popped_valid <= 1'b1;
      end
      err_out <= w_err;
    end
  end

endmodule

// File: tb/tb_fila_ctrl.sv
// tb/tb_fila_ctrl.sv - self-checking bench for fila_ctrl with a behavioural reference model
module tb_fila_ctrl;

  localparam int DB    = 5;
  localparam int DEPTH = 8;

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_enq   = 1'b0;
  logic       btn_deq   = 1'b0;
  logic [7:0] sw_data   = 8'h00;
  logic [7:0] len_in    = 8'h00;
  logic [7:0] data_in   = 8'h00;
  logic       enqueue_out;
  logic       dequeue_out;
  logic [7:0] data_to_fila;
  logic [7:0] popped_out;
  logic       popped_valid;
  logic       full_out;
  logic       empty_out;
  logic       err_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_enq  = 0;
  int cnt_deq  = 0;
  int cnt_pv   = 0;
  int cnt_err  = 0;

  fila_ctrl #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEPTH)) dut (
    .clk_10KHz   (clk_10KHz),
    .reset       (reset),
    .btn_enq     (btn_enq),
    .btn_deq     (btn_deq),
    .sw_data     (sw_data),
    .len_in      (len_in),
    .data_in     (data_in),
    .enqueue_out (enqueue_out),
    .dequeue_out (dequeue_out),
    .data_to_fila(data_to_fila),
    .popped_out  (popped_out),
    .popped_valid(popped_valid),
    .full_out    (full_out),
    .empty_out   (empty_out),
    .err_out     (err_out)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue environment: behaves like the byte queue, data_out holds the last popped byte.
  logic [7:0] env_q[$];
  always @(posedge clk_10KHz) begin
    if (dequeue_out && env_q.size() > 0) data_in <= env_q.pop_front();
    if (enqueue_out && env_q.size() < DEPTH) env_q.push_back(data_to_fila);
    len_in <= 8'(env_q.size());
  end

  // Reference model: window-based debounce, pending flags, and a busy timer for service.
  logic [7:0] m_q[$];
  bit         m_d1 [2];
  bit         m_d2 [2];
  bit         m_db [2];
  bit         m_pend [2];
  bit         m_win [2][DB];
  int         m_busy  = 0;
  int         m_pv_cd = 0;
  logic [7:0] m_pop   = 8'h00;
  bit         x_enq = 0, x_deq = 0, x_err = 0, x_pv = 0;
  logic [7:0] x_data = 8'h00, x_popped = 8'h00;

  always @(posedge clk_10KHz) begin
    bit pend_before [2];
    bit sync_now;
    bit all_diff;
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_db[b] = 0; m_pend[b] = 0;
        for (int i = 0; i < DB; i++) m_win[b][i] = 0;
      end
      m_busy = 0; m_pv_cd = 0;
      x_enq = 0; x_deq = 0; x_err = 0; x_pv = 0;
      x_data = 8'h00; x_popped = 8'h00;
    end else begin
      if (x_enq) m_q.push_back(x_data);
      if (x_deq && m_q.size() > 0) m_pop = m_q.pop_front();
      x_pv = 0;
      if (m_pv_cd > 0) begin
        m_pv_cd--;
        if (m_pv_cd == 0) begin
          x_pv = 1;
          x_popped = m_pop;
        end
      end
      x_enq = 0; x_deq = 0; x_err = 0;
      pend_before = m_pend;
      if (m_busy > 0) begin
        m_busy--;
      end else if (m_pend[0]) begin
        m_pend[0] = 0;
        if (len_in >= DEPTH) x_err = 1;
        else begin x_enq = 1; x_data = sw_data; m_busy = 2; end
      end else if (m_pend[1]) begin
        m_pend[1] = 0;
        if (len_in == 0) x_err = 1;
        else begin x_deq = 1; m_busy = 2; m_pv_cd = 2; end
      end
      for (int b = 0; b < 2; b++) begin
        sync_now = m_d2[b];
        m_d2[b]  = m_d1[b];
        m_d1[b]  = (b == 0) ? btn_enq : btn_deq;
        for (int i = DB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
        m_win[b][0] = sync_now;
        all_diff = 1;
        for (int i = 0; i < DB; i++) if (m_win[b][i] == m_db[b]) all_diff = 0;
        if (all_diff) begin
          m_db[b] = ~m_db[b];
          if (m_db[b] && !pend_before[b]) m_pend[b] = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk_10KHz) begin
    cnt_enq += int'(enqueue_out);
    cnt_deq += int'(dequeue_out);
    cnt_pv  += int'(popped_valid);
    cnt_err += int'(err_out);
    if (reset) begin
      chk("rst_enqueue_out", enqueue_out, 0);
      chk("rst_dequeue_out", dequeue_out, 0);
      chk("rst_popped_valid", popped_valid, 0);
      chk("rst_err_out", err_out, 0);
      chk("rst_data_to_fila", data_to_fila, 8'h00);
      chk("rst_popped_out", popped_out, 8'h00);
    end else begin
      chk("enqueue_out", enqueue_out, x_enq);
      chk("dequeue_out", dequeue_out, x_deq);
      chk("popped_valid", popped_valid, x_pv);
      chk("err_out", err_out, x_err);
      chk("data_to_fila", data_to_fila, x_data);
      chk("popped_out", popped_out, x_popped);
    end
    chk("full_out", full_out, len_in >= DEPTH);
    chk("empty_out", empty_out, len_in == 8'd0);
  end

  function automatic logic sig_of(input int w);
    case (w)
      0:       return enqueue_out;
      1:       return dequeue_out;
      default: return popped_valid;
    endcase
  endfunction

  // Counts rising clock edges until the chosen output is seen high (bounded).
  task automatic wait_hi(input int w, input string name, output int c);
    c = 0;
    do begin
      @(posedge clk_10KHz); #1;
      c++;
    end while (!sig_of(w) && c < 60);
    chk(name, sig_of(w), 1);
  endtask

  task automatic set_btn(input bit e, input bit d, input logic v);
    if (e) btn_enq = v;
    if (d) btn_deq = v;
  endtask

  task automatic press(input bit e, input bit d);
    int nb;
    nb = $urandom_range(0, 3);
    for (int i = 0; i < nb; i++) begin
      set_btn(e, d, 1'b1);
      repeat ($urandom_range(1, DB - 1)) @(negedge clk_10KHz);
      set_btn(e, d, 1'b0);
      repeat ($urandom_range(1, DB - 1)) @(negedge clk_10KHz);
    end
    set_btn(e, d, 1'b1);
    repeat ($urandom_range(DB - 2, DB + 12)) @(negedge clk_10KHz);
    if ($urandom_range(0, 3) == 0) sw_data = 8'($urandom);
    set_btn(e, d, 1'b0);
    repeat ($urandom_range(0, DB + 8)) @(negedge clk_10KHz);
  endtask

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int c;
    int base_enq, base_deq, base_pv, base_err;
    bit e, d;
    int r;

    repeat (3) @(negedge clk_10KHz);
    chk("reset_enq_lit", enqueue_out, 0);
    chk("reset_empty_lit", empty_out, 1);
    chk("reset_full_lit", full_out, 0);
    #1 reset = 1'b0;

    // Bouncy enqueue button never stable long enough.
    base_enq = cnt_enq;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_10KHz); btn_enq = ~btn_enq;
      @(negedge clk_10KHz);
    end
    btn_enq = 1'b0;
    repeat (DB + 10) @(negedge clk_10KHz);
    chk("bounce_no_enq", cnt_enq - base_enq, 0);

    // Dequeue on an empty queue is refused.
    base_err = cnt_err; base_deq = cnt_deq;
    btn_deq = 1'b1;
    repeat (DB + 10) @(negedge clk_10KHz);
    btn_deq = 1'b0;
    repeat (DB + 8) @(negedge clk_10KHz);
    chk("empty_deq_err", cnt_err - base_err, 1);
    chk("empty_deq_nostrobe", cnt_deq - base_deq, 0);

    // Clean enqueue of A5, button held long afterwards.
    base_enq = cnt_enq;
    sw_data = 8'hA5;
    btn_enq = 1'b1;
    wait_hi(0, "enq_seen", c);
    chk("enq_latency", c, DB + 3);
    chk("enq_data_lit", data_to_fila, 8'hA5);
    repeat (20) @(negedge clk_10KHz);
    btn_enq = 1'b0;
    repeat (DB + 8) @(negedge clk_10KHz);
    chk("enq_single", cnt_enq - base_enq, 1);

    // Dequeue returns A5 two cycles after the strobe.
    base_pv = cnt_pv;
    btn_deq = 1'b1;
    wait_hi(1, "deq_seen", c);
    chk("deq_latency", c, DB + 3);
    wait_hi(2, "pv_seen", c);
    chk("pv_delay", c, 2);
    chk("popped_lit", popped_out, 8'hA5);
    @(posedge clk_10KHz); #1;
    chk("pv_one_cycle", popped_valid, 0);
    @(negedge clk_10KHz);
    btn_deq = 1'b0;
    repeat (DB + 8) @(negedge clk_10KHz);
    chk("pv_single", cnt_pv - base_pv, 1);

    // Simultaneous presses: enqueue first, dequeue three cycles later.
    sw_data = 8'h5A;
    btn_enq = 1'b1; btn_deq = 1'b1;
    wait_hi(0, "both_enq_seen", c);
    chk("both_enq_deq_low", dequeue_out, 0);
    wait_hi(1, "both_deq_seen", c);
    chk("both_spacing", c, 3);
    @(negedge clk_10KHz);
    btn_enq = 1'b0; btn_deq = 1'b0;
    repeat (DB + 8) @(negedge clk_10KHz);

    // Reset during the DEQ cycle.
    sw_data = 8'h77;
    btn_enq = 1'b1;
    repeat (DB + 8) @(negedge clk_10KHz);
    btn_enq = 1'b0;
    repeat (DB + 8) @(negedge clk_10KHz);
    base_pv = cnt_pv;
    btn_deq = 1'b1;
    wait_hi(1, "rst_deq_seen", c);
    btn_deq = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_async_deq_drop", dequeue_out, 0);
    repeat (2) @(negedge clk_10KHz);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk_10KHz);
    chk("rst_no_pv", cnt_pv - base_pv, 0);
    chk("rst_popped_zero", popped_out, 8'h00);

    // Randomized phases: enqueue-heavy to reach full, then dequeue-heavy to reach empty.
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 60; k++) begin
        r = $urandom_range(0, 99);
        e = (ph == 0) ? (r < 75) : (r < 25);
        d = !e;
        if (r % 10 == 0) begin e = 1; d = 1; end
        sw_data = 8'($urandom);
        press(e, d);
      end
    end
    repeat (DB + 20) @(negedge clk_10KHz);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
